// File: rtl/key_entry_pkg.sv
// Shared types and constants for the operator key entry front end.
package key_entry_pkg;

  localparam int DEB_TICKS_DEF = 4;
  localparam int NUM_KEYS      = 4;
  localparam int VAL_W         = 4;

  localparam logic FIELD_DATA = 1'b0;
  localparam logic FIELD_CRE  = 1'b1;

  typedef enum logic {EDIT = 1'b0, HOLD = 1'b1} state_t;

  // One-cycle press pulses; bit order matches the raw key vector.
  typedef struct packed {
    logic ok;
    logic sel;
    logic dec;
    logic inc;
  } key_t;

  // Modulo-16 step; inc and dec together cancel.
  function automatic logic [VAL_W-1:0] step_val(input logic [VAL_W-1:0] v,
                                                input logic up, input logic dn);
    logic [VAL_W-1:0] r;
    r = v;
    if (up && !dn)      r = v + VAL_W'(1);
    else if (dn && !up) r = v - VAL_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw key: 2-flop synchronizer, tick-sampled debouncer, registered rise pulse.
module btn_debounce #(
  parameter int DEB_TICKS = 4,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic rise
);

  logic [1:0]       sync_pipe;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_pipe <= '0;
    else      sync_pipe <= {sync_pipe[0], raw};
  end

  // Any cycle where the synced level agrees with the debounced one restarts the run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync_pipe[1] == level) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CNT_W'(DEB_TICKS - 1)) begin
          level <= ~level;
          cnt   <= '0;
          rise  <= ~level;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/key_entry.sv
// Debounced inc/dec/sel/ok keys editing data and credential nibbles, committed over valid/ready.
module key_entry
  import key_entry_pkg::*;
#(
  parameter int DEB_TICKS = DEB_TICKS_DEF,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             btn_inc,
  input  logic             btn_dec,
  input  logic             btn_sel,
  input  logic             btn_ok,
  input  logic             ready,
  output logic [VAL_W-1:0] ubData,
  output logic [VAL_W-1:0] ubCre,
  output logic             field,
  output logic             valid
);

  logic [NUM_KEYS-1:0] raw, rise;
  key_t                keys;

  assign raw  = {btn_ok, btn_sel, btn_dec, btn_inc};
  assign keys = key_t'(rise);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    btn_debounce #(.DEB_TICKS(DEB_TICKS), .CNT_W(CNT_W)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .raw  (raw[i]),
      .rise (rise[i])
    );
  end

  state_t           state, state_n;
  logic [VAL_W-1:0] data_n, cre_n;
  logic             field_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EDIT;
      ubData <= '0;
      ubCre  <= '0;
      field  <= FIELD_DATA;
      valid  <= 1'b0;
    end else begin
      state  <= state_n;
      ubData <= data_n;
      ubCre  <= cre_n;
      field  <= field_n;
      valid  <= (state_n == HOLD);
    end
  end

  // ok preempts edits; sel toggles after the value change on the current field.
  always_comb begin
    state_n = state;
    data_n  = ubData;
    cre_n   = ubCre;
    field_n = field;
    case (state)
      EDIT: begin
        if (keys.ok) begin
          state_n = HOLD;
        end else begin
          if (field == FIELD_CRE) cre_n  = step_val(ubCre,  keys.inc, keys.dec);
          else                    data_n = step_val(ubData, keys.inc, keys.dec);
          if (keys.sel) field_n = ~field;
        end
      end
      HOLD: begin
        if (valid && ready) begin
          state_n = EDIT;
          data_n  = '0;
          cre_n   = '0;
          field_n = FIELD_DATA;
        end
      end
      default: state_n = EDIT;
    endcase
  end

endmodule

// File: tb/tb_key_entry.sv
// Self-checking bench: directed test-plan sequences plus random keys against a behavioural model.
module tb_key_entry;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] btn = 4'b0;   // {ok, sel, dec, inc}
  logic       ready = 1'b0;
  logic [3:0] ubData, ubCre;
  logic       field, valid;

  int  total = 0;
  int  bad = 0;
  bit  rnd_mode = 1'b0;
  bit  chk_en = 1'b0;

  key_entry #(.DEB_TICKS(DEB), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .btn_inc(btn[0]), .btn_dec(btn[1]), .btn_sel(btn[2]), .btn_ok(btn[3]),
    .ready(ready), .ubData(ubData), .ubCre(ubCre), .field(field), .valid(valid)
  );

  always #5 clk = ~clk;

  // Behavioural model: integers for the values, sample history per key.
  int m_d = 0, m_c = 0, m_f = 0, m_v = 0;
  int run [4] = '{0, 0, 0, 0};
  bit lvl [4] = '{0, 0, 0, 0};
  bit pls [4] = '{0, 0, 0, 0};
  bit hist1 [4] = '{0, 0, 0, 0};
  bit hist2 [4] = '{0, 0, 0, 0};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_d = 0; m_c = 0; m_f = 0; m_v = 0;
      for (int k = 0; k < 4; k++) begin
        run[k] = 0; lvl[k] = 0; pls[k] = 0; hist1[k] = 0; hist2[k] = 0;
      end
    end else begin
      if (m_v == 1) begin
        if (ready) begin m_d = 0; m_c = 0; m_f = 0; m_v = 0; end
      end else if (pls[3]) begin
        m_v = 1;
      end else begin
        int dlt;
        dlt = int'(pls[0]) - int'(pls[1]);
        if (m_f == 1) m_c = (m_c + dlt + 16) % 16;
        else          m_d = (m_d + dlt + 16) % 16;
        if (pls[2]) m_f = 1 - m_f;
      end
      for (int k = 0; k < 4; k++) begin
        bit np;
        np = 0;
        // the key as seen two samples ago must disagree for DEB consecutive ticks
        if (hist2[k] == lvl[k]) run[k] = 0;
        else if (tick) begin
          run[k]++;
          if (run[k] == DEB) begin
            lvl[k] = hist2[k];
            run[k] = 0;
            np = hist2[k];
          end
        end
        pls[k] = np;
        hist2[k] = hist1[k];
        hist1[k] = btn[k];
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model ubData", int'(ubData), m_d);
      chk("model ubCre",  int'(ubCre),  m_c);
      chk("model field",  int'(field),  m_f);
      chk("model valid",  int'(valid),  m_v);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      tick = rnd_mode ? ($urandom_range(0, 1) == 1) : ~tick;
    end
  endtask

  task automatic press(input int k, input int times);
    repeat (times) begin
      btn[k] = 1'b1; step(20);
      btn[k] = 1'b0; step(20);
    end
  endtask

  task automatic press2(input int a, input int b);
    btn[a] = 1'b1; btn[b] = 1'b1; step(20);
    btn[a] = 1'b0; btn[b] = 1'b0; step(20);
  endtask

  initial begin
    step(3);
    chk("reset ubData", int'(ubData), 0);
    chk("reset ubCre",  int'(ubCre),  0);
    chk("reset field",  int'(field),  0);
    chk("reset valid",  int'(valid),  0);
    rst = 1'b1;
    chk_en = 1'b1;
    step(2);

    press(0, 3);
    chk("three inc data", int'(ubData), 3);
    chk("three inc cre",  int'(ubCre),  0);
    chk("three inc valid", int'(valid), 0);

    press(0, 12);
    chk("data at 15", int'(ubData), 15);
    press(0, 1);
    chk("data wrap 15->0", int'(ubData), 0);
    press(2, 1);
    chk("sel field", int'(field), 1);
    press(1, 1);
    chk("cre wrap 0->15", int'(ubCre), 15);

    // bounce: high for DEB-1 ticks (tick every other cycle), then low
    repeat (5) begin
      btn[0] = 1'b1; step(2 * (DEB - 1));
      btn[0] = 1'b0; step(2 * (DEB - 1));
    end
    step(20);
    chk("bounce ignored", int'(ubCre), 15);
    press(0, 1);
    chk("stable after bounce", int'(ubCre), 0);

    press(0, 9);
    press(2, 1);
    press(0, 5);
    chk("setup data 5", int'(ubData), 5);
    chk("setup cre 9",  int'(ubCre),  9);
    press(3, 1);
    chk("ok valid", int'(valid), 1);
    press(0, 1);
    chk("hold data", int'(ubData), 5);
    chk("hold cre",  int'(ubCre),  9);
    chk("hold valid", int'(valid), 1);
    ready = 1'b1; step(1);
    ready = 1'b0; step(2);
    chk("accept valid", int'(valid), 0);
    chk("accept data", int'(ubData), 0);
    chk("accept cre",  int'(ubCre),  0);
    chk("accept field", int'(field), 0);

    press(0, 7);
    press2(0, 1);
    chk("inc+dec cancel", int'(ubData), 7);
    press2(3, 0);
    chk("ok+inc valid", int'(valid), 1);
    chk("ok+inc data", int'(ubData), 7);
    ready = 1'b1; step(1);
    ready = 1'b0; step(2);
    chk("second accept valid", int'(valid), 0);

    press(2, 1);
    press(0, 4);
    press(3, 1);
    chk("pre-reset valid", int'(valid), 1);
    chk("pre-reset cre", int'(ubCre), 4);
    rst = 1'b0;
    #1;
    chk("async rst valid", int'(valid), 0);
    chk("async rst cre", int'(ubCre), 0);
    chk("async rst field", int'(field), 0);
    step(2);
    rst = 1'b1;
    step(2);
    press(0, 1);
    chk("edit after reset", int'(ubData), 1);
    chk("edit after reset valid", int'(valid), 0);

    // random phase: ready already high at commit gives a one-cycle valid
    rnd_mode = 1'b1;
    ready = 1'b1;
    press(3, 1);
    ready = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 24) == 0) btn[k] = ~btn[k];
      ready = ($urandom_range(0, 5) == 0);
      step(1);
    end
    btn = 4'b0;
    ready = 1'b1;
    step(50);
    chk("final idle valid", int'(valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
